// File: rtl/ysyx_24110006_axi_pkg.sv
// Shared AXI definitions for the read-channel arbiter: FSM encodings,
// burst/size/response constants and a small beat-count helper.
package ysyx_24110006_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } axi_rd_state_e;

  localparam logic [1:0] BURST_FIXED  = 2'b00;
  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [2:0] SIZE_4B      = 3'b010;
  localparam int         ID_WIDTH_DEF = 4;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  // An accepted beat is malformed when rlast disagrees with the beat index:
  // rlast before the final index, or the final index without rlast.
  function automatic logic beat_len_err(input logic       last,
                                        input logic [7:0] cnt,
                                        input logic [7:0] len);
    logic err;
    if (last) begin
      err = (cnt != len);
    end else begin
      err = (cnt == len);
    end
    return err;
  endfunction

endpackage

// File: rtl/ysyx_24110006_rr_arb2.sv
// Two-input round-robin picker. When both inputs request, the one that did
// not win last time is chosen; a lone requester always wins.
module ysyx_24110006_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_idx,
  output logic       any
);

  // Select the winner from the request vector and the previous winner
  always_comb begin
    grant_idx = 1'b0;
    any       = 1'b0;
    case (req)
      2'b01: begin
        grant_idx = 1'b0;
        any       = 1'b1;
      end
      2'b10: begin
        grant_idx = 1'b1;
        any       = 1'b1;
      end
      2'b11: begin
        grant_idx = ~last;
        any       = 1'b1;
      end
      default: begin
        grant_idx = 1'b0;
        any       = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_24110006_axi_rd_arbiter.sv
// Shares one AXI4 read port between the ICACHE (master 0) and the LSU
// (master 1). One transaction at a time: the AR request is latched and
// re-driven from registers, then R beats are steered straight through to
// the granted master until the rlast handshake releases the grant.
module ysyx_24110006_axi_rd_arbiter
  import ysyx_24110006_axi_pkg::*;
#(
  parameter int ID_WIDTH = ID_WIDTH_DEF
) (
  input  logic                i_clock,
  input  logic                i_reset,
  // master 0 (ICACHE)
  input  logic                i_m0_arvalid,
  output logic                o_m0_arready,
  input  logic [31:0]         i_m0_araddr,
  input  logic [7:0]          i_m0_arlen,
  input  logic [2:0]          i_m0_arsize,
  input  logic [1:0]          i_m0_arburst,
  output logic [31:0]         o_m0_rdata,
  output logic                o_m0_rvalid,
  input  logic                i_m0_rready,
  output logic [1:0]          o_m0_rresp,
  output logic                o_m0_rlast,
  // master 1 (LSU)
  input  logic                i_m1_arvalid,
  output logic                o_m1_arready,
  input  logic [31:0]         i_m1_araddr,
  input  logic [7:0]          i_m1_arlen,
  input  logic [2:0]          i_m1_arsize,
  input  logic [1:0]          i_m1_arburst,
  output logic [31:0]         o_m1_rdata,
  output logic                o_m1_rvalid,
  input  logic                i_m1_rready,
  output logic [1:0]          o_m1_rresp,
  output logic                o_m1_rlast,
  // shared port
  output logic [31:0]         o_axi_araddr,
  output logic [7:0]          o_axi_arlen,
  output logic [2:0]          o_axi_arsize,
  output logic [1:0]          o_axi_arburst,
  output logic [ID_WIDTH-1:0] o_axi_arid,
  output logic                o_axi_arvalid,
  input  logic                i_axi_arready,
  input  logic [31:0]         i_axi_rdata,
  input  logic [1:0]          i_axi_rresp,
  input  logic [ID_WIDTH-1:0] i_axi_rid,
  input  logic                i_axi_rlast,
  input  logic                i_axi_rvalid,
  output logic                o_axi_rready,
  output logic                o_proto_err
);

  axi_rd_state_e       state_r, state_n_s;
  logic                grant_r, grant_n_s;
  logic                last_grant_r, last_grant_n_s;
  logic [7:0]          beat_cnt_r, beat_cnt_n_s;
  logic [31:0]         araddr_r, araddr_n_s;
  logic [7:0]          arlen_r, arlen_n_s;
  logic [2:0]          arsize_r, arsize_n_s;
  logic [1:0]          arburst_r, arburst_n_s;
  logic                proto_err_r, proto_err_n_s;

  logic                arb_idx_s;
  logic                arb_any_s;
  logic                rready_s;
  logic                beat_fire_s;
  logic [ID_WIDTH-1:0] grant_id_s;

  ysyx_24110006_rr_arb2 u_rr_arb2 (
    .req       ({i_m1_arvalid, i_m0_arvalid}),
    .last      (last_grant_r),
    .grant_idx (arb_idx_s),
    .any       (arb_any_s)
  );

  assign grant_id_s    = ID_WIDTH'(grant_r);

  // Shared AR channel comes straight from registers so it is glitch-free
  // and stable for the whole ADDR phase.
  assign o_axi_araddr  = araddr_r;
  assign o_axi_arlen   = arlen_r;
  assign o_axi_arsize  = arsize_r;
  assign o_axi_arburst = arburst_r;
  assign o_axi_arid    = grant_id_s;
  assign o_axi_arvalid = (state_r == ST_ADDR);
  assign o_proto_err   = proto_err_r;

  // State, grant bookkeeping and latched request registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r      <= ST_IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      beat_cnt_r   <= 8'd0;
      araddr_r     <= 32'd0;
      arlen_r      <= 8'd0;
      arsize_r     <= 3'd0;
      arburst_r    <= 2'd0;
      proto_err_r  <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      grant_r      <= grant_n_s;
      last_grant_r <= last_grant_n_s;
      beat_cnt_r   <= beat_cnt_n_s;
      araddr_r     <= araddr_n_s;
      arlen_r      <= arlen_n_s;
      arsize_r     <= arsize_n_s;
      arburst_r    <= arburst_n_s;
      proto_err_r  <= proto_err_n_s;
    end
  end

  // Next-state, arbitration, R routing and protocol checking
  always_comb begin
    state_n_s      = state_r;
    grant_n_s      = grant_r;
    last_grant_n_s = last_grant_r;
    beat_cnt_n_s   = beat_cnt_r;
    araddr_n_s     = araddr_r;
    arlen_n_s      = arlen_r;
    arsize_n_s     = arsize_r;
    arburst_n_s    = arburst_r;
    proto_err_n_s  = proto_err_r;
    rready_s       = 1'b0;
    beat_fire_s    = 1'b0;

    o_m0_arready   = 1'b0;
    o_m1_arready   = 1'b0;
    o_m0_rvalid    = 1'b0;
    o_m0_rdata     = 32'd0;
    o_m0_rresp     = RESP_OKAY;
    o_m0_rlast     = 1'b0;
    o_m1_rvalid    = 1'b0;
    o_m1_rdata     = 32'd0;
    o_m1_rresp     = RESP_OKAY;
    o_m1_rlast     = 1'b0;
    o_axi_rready   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // arready is gated by reset so every output is low while held in reset
        if (arb_any_s && i_reset) begin
          grant_n_s    = arb_idx_s;
          beat_cnt_n_s = 8'd0;
          state_n_s    = ST_ADDR;
          if (arb_idx_s) begin
            o_m1_arready = 1'b1;
            araddr_n_s   = i_m1_araddr;
            arlen_n_s    = i_m1_arlen;
            arsize_n_s   = i_m1_arsize;
            arburst_n_s  = i_m1_arburst;
          end else begin
            o_m0_arready = 1'b1;
            araddr_n_s   = i_m0_araddr;
            arlen_n_s    = i_m0_arlen;
            arsize_n_s   = i_m0_arsize;
            arburst_n_s  = i_m0_arburst;
          end
        end else begin
          state_n_s = ST_IDLE;
        end
      end

      ST_ADDR: begin
        // R beats arriving before the address is taken are left unaccepted
        if (i_axi_arready) begin
          state_n_s = ST_DATA;
        end else begin
          state_n_s = ST_ADDR;
        end
      end

      ST_DATA: begin
        if (grant_r) begin
          rready_s    = i_m1_rready;
          o_m1_rvalid = i_axi_rvalid;
          o_m1_rdata  = i_axi_rdata;
          o_m1_rresp  = i_axi_rresp;
          o_m1_rlast  = i_axi_rlast;
        end else begin
          rready_s    = i_m0_rready;
          o_m0_rvalid = i_axi_rvalid;
          o_m0_rdata  = i_axi_rdata;
          o_m0_rresp  = i_axi_rresp;
          o_m0_rlast  = i_axi_rlast;
        end
        o_axi_rready = rready_s;
        beat_fire_s  = i_axi_rvalid && rready_s;

        if (beat_fire_s) begin
          beat_cnt_n_s = beat_cnt_r + 8'd1;
          // Errors are only flagged; the beat is still delivered as-is
          if (beat_len_err(i_axi_rlast, beat_cnt_r, arlen_r) ||
              (i_axi_rid != grant_id_s)) begin
            proto_err_n_s = 1'b1;
          end else begin
            proto_err_n_s = proto_err_r;
          end
          // rlast ends the burst even if it came early, so the port never hangs
          if (i_axi_rlast) begin
            last_grant_n_s = grant_r;
            state_n_s      = ST_IDLE;
          end else begin
            state_n_s = ST_DATA;
          end
        end else begin
          state_n_s = ST_DATA;
        end
      end

      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_24110006_axi_rd_arbiter.sv
// Directed self-checking bench for the two-master AXI read arbiter.
// Inputs are driven 1 time unit after the rising edge, outputs are
// compared 1 time unit later.
module tb_ysyx_24110006_axi_rd_arbiter;

  logic        i_clock;
  logic        i_reset;
  logic        i_m0_arvalid, i_m1_arvalid;
  logic        o_m0_arready, o_m1_arready;
  logic [31:0] i_m0_araddr, i_m1_araddr;
  logic [7:0]  i_m0_arlen, i_m1_arlen;
  logic [2:0]  i_m0_arsize, i_m1_arsize;
  logic [1:0]  i_m0_arburst, i_m1_arburst;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic        o_m0_rvalid, o_m1_rvalid;
  logic        i_m0_rready, i_m1_rready;
  logic [1:0]  o_m0_rresp, o_m1_rresp;
  logic        o_m0_rlast, o_m1_rlast;
  logic [31:0] o_axi_araddr;
  logic [7:0]  o_axi_arlen;
  logic [2:0]  o_axi_arsize;
  logic [1:0]  o_axi_arburst;
  logic [3:0]  o_axi_arid;
  logic        o_axi_arvalid;
  logic        i_axi_arready;
  logic [31:0] i_axi_rdata;
  logic [1:0]  i_axi_rresp;
  logic [3:0]  i_axi_rid;
  logic        i_axi_rlast;
  logic        i_axi_rvalid;
  logic        o_axi_rready;
  logic        o_proto_err;

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_24110006_axi_rd_arbiter #(.ID_WIDTH(4)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_m0_arvalid(i_m0_arvalid), .o_m0_arready(o_m0_arready),
    .i_m0_araddr(i_m0_araddr), .i_m0_arlen(i_m0_arlen),
    .i_m0_arsize(i_m0_arsize), .i_m0_arburst(i_m0_arburst),
    .o_m0_rdata(o_m0_rdata), .o_m0_rvalid(o_m0_rvalid),
    .i_m0_rready(i_m0_rready), .o_m0_rresp(o_m0_rresp), .o_m0_rlast(o_m0_rlast),
    .i_m1_arvalid(i_m1_arvalid), .o_m1_arready(o_m1_arready),
    .i_m1_araddr(i_m1_araddr), .i_m1_arlen(i_m1_arlen),
    .i_m1_arsize(i_m1_arsize), .i_m1_arburst(i_m1_arburst),
    .o_m1_rdata(o_m1_rdata), .o_m1_rvalid(o_m1_rvalid),
    .i_m1_rready(i_m1_rready), .o_m1_rresp(o_m1_rresp), .o_m1_rlast(o_m1_rlast),
    .o_axi_araddr(o_axi_araddr), .o_axi_arlen(o_axi_arlen),
    .o_axi_arsize(o_axi_arsize), .o_axi_arburst(o_axi_arburst),
    .o_axi_arid(o_axi_arid), .o_axi_arvalid(o_axi_arvalid),
    .i_axi_arready(i_axi_arready), .i_axi_rdata(i_axi_rdata),
    .i_axi_rresp(i_axi_rresp), .i_axi_rid(i_axi_rid),
    .i_axi_rlast(i_axi_rlast), .i_axi_rvalid(i_axi_rvalid),
    .o_axi_rready(o_axi_rready), .o_proto_err(o_proto_err)
  );

  // 10-unit free-running clock
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic cyc();
    @(posedge i_clock);
    #1;
  endtask

  // Request from the masters in reqs, expect exp_m to win, then walk ADDR
  task automatic grant_cycle(input logic [1:0] reqs, input logic exp_m,
                             input logic [31:0] addr0, input logic [31:0] addr1,
                             input logic [7:0] len);
    logic [31:0] exp_addr;
    logic [1:0]  exp_rdy;
    exp_addr = exp_m ? addr1 : addr0;
    exp_rdy  = exp_m ? 2'b10 : 2'b01;
    i_m0_arvalid = reqs[0]; i_m0_araddr = addr0; i_m0_arlen = len;
    i_m0_arsize = 3'b010; i_m0_arburst = 2'b01;
    i_m1_arvalid = reqs[1]; i_m1_araddr = addr1; i_m1_arlen = len;
    i_m1_arsize = 3'b010; i_m1_arburst = 2'b01;
    #1;
    n_cmp++; if ({o_m1_arready, o_m0_arready} !== exp_rdy) begin
      n_bad++; $display("FAIL grant_arready: got %b want %b", {o_m1_arready, o_m0_arready}, exp_rdy); end
    n_cmp++; if (o_axi_arvalid !== 1'b0) begin
      n_bad++; $display("FAIL arvalid_early: got %b want 0", o_axi_arvalid); end
    cyc();
    if (exp_m) i_m1_arvalid = 1'b0; else i_m0_arvalid = 1'b0;
    i_axi_rvalid = 1'b1;
    #1;
    n_cmp++; if (o_axi_arvalid !== 1'b1) begin
      n_bad++; $display("FAIL arvalid: got %b want 1", o_axi_arvalid); end
    n_cmp++; if (o_axi_araddr !== exp_addr || o_axi_arlen !== len) begin
      n_bad++; $display("FAIL ar_fields: got %h/%h want %h/%h", o_axi_araddr, o_axi_arlen, exp_addr, len); end
    n_cmp++; if (o_axi_arsize !== 3'b010 || o_axi_arburst !== 2'b01) begin
      n_bad++; $display("FAIL ar_size_burst: got %b/%b want 010/01", o_axi_arsize, o_axi_arburst); end
    n_cmp++; if (o_axi_arid !== {3'b000, exp_m}) begin
      n_bad++; $display("FAIL arid: got %h want %h", o_axi_arid, {3'b000, exp_m}); end
    n_cmp++; if (o_axi_rready !== 1'b0 || o_m0_rvalid !== 1'b0 || o_m1_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL addr_r_blocked: got %b%b%b want 000", o_axi_rready, o_m0_rvalid, o_m1_rvalid); end
    n_cmp++; if ({o_m1_arready, o_m0_arready} !== 2'b00) begin
      n_bad++; $display("FAIL addr_arready: got %b want 00", {o_m1_arready, o_m0_arready}); end
    i_axi_rvalid = 1'b0;
    cyc();
    #1;
    n_cmp++; if (o_axi_arvalid !== 1'b1 || o_axi_araddr !== exp_addr) begin
      n_bad++; $display("FAIL ar_hold: got %b/%h want 1/%h", o_axi_arvalid, o_axi_araddr, exp_addr); end
    i_axi_arready = 1'b1;
    cyc();
    i_axi_arready = 1'b0;
    #1;
    n_cmp++; if (o_axi_arvalid !== 1'b0) begin
      n_bad++; $display("FAIL arvalid_drop: got %b want 0", o_axi_arvalid); end
  endtask

  // Deliver nbeats beats to master m; optional stall and early/late rlast
  task automatic burst(input logic m, input int nbeats, input int rlast_at,
                       input logic [3:0] rid, input int stall_at, input int stall_n);
    logic [31:0] d;
    logic        sel_v, oth_v, sel_l;
    logic [31:0] sel_d, oth_d;
    logic [1:0]  sel_r;
    for (int b = 0; b < nbeats; b++) begin
      d = {8'hD0, 7'd0, m, 8'd0, b[7:0]};
      i_axi_rvalid = 1'b1; i_axi_rdata = d; i_axi_rresp = b[1:0];
      i_axi_rid = rid; i_axi_rlast = (b == rlast_at);
      if (b == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          if (m) begin i_m1_rready = 1'b0; i_m0_rready = 1'b1; end
          else begin i_m0_rready = 1'b0; i_m1_rready = 1'b1; end
          #1;
          sel_v = m ? o_m1_rvalid : o_m0_rvalid;
          sel_d = m ? o_m1_rdata : o_m0_rdata;
          n_cmp++; if (o_axi_rready !== 1'b0) begin
            n_bad++; $display("FAIL stall_rready: got %b want 0", o_axi_rready); end
          n_cmp++; if (sel_v !== 1'b1 || sel_d !== d) begin
            n_bad++; $display("FAIL stall_hold: got %b/%h want 1/%h", sel_v, sel_d, d); end
          cyc();
        end
      end
      if (m) begin i_m1_rready = 1'b1; i_m0_rready = 1'b0; end
      else begin i_m0_rready = 1'b1; i_m1_rready = 1'b0; end
      #1;
      sel_v = m ? o_m1_rvalid : o_m0_rvalid;
      sel_d = m ? o_m1_rdata : o_m0_rdata;
      sel_r = m ? o_m1_rresp : o_m0_rresp;
      sel_l = m ? o_m1_rlast : o_m0_rlast;
      oth_v = m ? o_m0_rvalid : o_m1_rvalid;
      oth_d = m ? o_m0_rdata : o_m1_rdata;
      n_cmp++; if (sel_v !== 1'b1 || sel_d !== d) begin
        n_bad++; $display("FAIL beat_route: got %b/%h want 1/%h", sel_v, sel_d, d); end
      n_cmp++; if (sel_r !== b[1:0] || sel_l !== (b == rlast_at)) begin
        n_bad++; $display("FAIL beat_resp_last: got %b/%b want %b/%b", sel_r, sel_l, b[1:0], (b == rlast_at)); end
      n_cmp++; if (oth_v !== 1'b0 || oth_d !== 32'd0) begin
        n_bad++; $display("FAIL other_quiet: got %b/%h want 0/0", oth_v, oth_d); end
      n_cmp++; if (o_axi_rready !== 1'b1) begin
        n_bad++; $display("FAIL beat_rready: got %b want 1", o_axi_rready); end
      cyc();
    end
    i_axi_rvalid = 1'b0; i_axi_rlast = 1'b0;
    i_m0_rready = 1'b0; i_m1_rready = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    i_m0_arvalid = 1'b1; i_m1_arvalid = 1'b1;
    repeat (2) cyc();
    n_cmp++; if ({o_m1_arready, o_m0_arready} !== 2'b00) begin
      n_bad++; $display("FAIL reset_arready: got %b want 00", {o_m1_arready, o_m0_arready}); end
    n_cmp++; if (o_axi_arvalid !== 1'b0 || o_axi_araddr !== 32'd0 || o_axi_arlen !== 8'd0 || o_axi_arid !== 4'd0) begin
      n_bad++; $display("FAIL reset_ar: got %b/%h/%h/%h want 0/0/0/0", o_axi_arvalid, o_axi_araddr, o_axi_arlen, o_axi_arid); end
    n_cmp++; if (o_axi_rready !== 1'b0 || o_proto_err !== 1'b0 || o_m0_rvalid !== 1'b0 || o_m1_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL reset_misc: got %b%b%b%b want 0000", o_axi_rready, o_proto_err, o_m0_rvalid, o_m1_rvalid); end
    i_m0_arvalid = 1'b0; i_m1_arvalid = 1'b0;
    cyc();
    i_reset = 1'b1;
  endtask

  task automatic test_round_robin();
    grant_cycle(2'b11, 1'b0, 32'h1000_0000, 32'h2000_0000, 8'd1);
    burst(1'b0, 2, 1, 4'd0, -1, 0);
    grant_cycle(2'b10, 1'b1, 32'h1000_0000, 32'h2000_0000, 8'd1);
    burst(1'b1, 2, 1, 4'd1, -1, 0);
    grant_cycle(2'b11, 1'b0, 32'h1000_0040, 32'h2000_0040, 8'd1);
    burst(1'b0, 2, 1, 4'd0, -1, 0);
    grant_cycle(2'b10, 1'b1, 32'h1000_0040, 32'h2000_0040, 8'd1);
    burst(1'b1, 2, 1, 4'd1, -1, 0);
    n_cmp++; if (o_proto_err !== 1'b0) begin
      n_bad++; $display("FAIL rr_err: got %b want 0", o_proto_err); end
  endtask

  task automatic test_single_m0();
    grant_cycle(2'b01, 1'b0, 32'h8000_0000, 32'h0, 8'd3);
    burst(1'b0, 4, 3, 4'd0, -1, 0);
    i_axi_rvalid = 1'b1;
    #1;
    n_cmp++; if (o_axi_rready !== 1'b0 || o_m0_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_burst: got %b/%b want 0/0", o_axi_rready, o_m0_rvalid); end
    n_cmp++; if (o_proto_err !== 1'b0) begin
      n_bad++; $display("FAIL single_err: got %b want 0", o_proto_err); end
    i_axi_rvalid = 1'b0;
  endtask

  task automatic test_stall();
    grant_cycle(2'b10, 1'b1, 32'h0, 32'h3000_0000, 8'd3);
    burst(1'b1, 4, 3, 4'd1, 1, 3);
    n_cmp++; if (o_proto_err !== 1'b0) begin
      n_bad++; $display("FAIL stall_err: got %b want 0", o_proto_err); end
  endtask

  task automatic test_early_rlast();
    grant_cycle(2'b01, 1'b0, 32'h4000_0000, 32'h0, 8'd3);
    burst(1'b0, 3, 2, 4'd0, -1, 0);
    n_cmp++; if (o_proto_err !== 1'b1) begin
      n_bad++; $display("FAIL early_rlast_err: got %b want 1", o_proto_err); end
    grant_cycle(2'b01, 1'b0, 32'h4000_0100, 32'h0, 8'd0);
    burst(1'b0, 1, 0, 4'd0, -1, 0);
    n_cmp++; if (o_proto_err !== 1'b1) begin
      n_bad++; $display("FAIL err_sticky: got %b want 1", o_proto_err); end
  endtask

  task automatic test_reset_mid_data();
    grant_cycle(2'b10, 1'b1, 32'h0, 32'h5000_0000, 8'd3);
    i_axi_rvalid = 1'b1; i_axi_rdata = 32'hCAFE_0001; i_axi_rid = 4'd1; i_m1_rready = 1'b1;
    #1;
    n_cmp++; if (o_m1_rvalid !== 1'b1 || o_m1_rdata !== 32'hCAFE_0001) begin
      n_bad++; $display("FAIL pre_reset_route: got %b/%h want 1/cafe0001", o_m1_rvalid, o_m1_rdata); end
    i_reset = 1'b0;
    #1;
    n_cmp++; if (o_m1_rvalid !== 1'b0 || o_m1_rdata !== 32'd0 || o_axi_rready !== 1'b0) begin
      n_bad++; $display("FAIL async_reset_r: got %b/%h/%b want 0/0/0", o_m1_rvalid, o_m1_rdata, o_axi_rready); end
    n_cmp++; if (o_axi_arvalid !== 1'b0 || o_axi_araddr !== 32'd0 || o_axi_arid !== 4'd0 || o_proto_err !== 1'b0) begin
      n_bad++; $display("FAIL async_reset_ar: got %b/%h/%h/%b want 0/0/0/0", o_axi_arvalid, o_axi_araddr, o_axi_arid, o_proto_err); end
    i_axi_rvalid = 1'b0; i_m1_rready = 1'b0;
    cyc();
    i_reset = 1'b1;
    grant_cycle(2'b11, 1'b0, 32'h6000_0000, 32'h7000_0000, 8'd0);
    burst(1'b0, 1, 0, 4'd0, -1, 0);
    grant_cycle(2'b10, 1'b1, 32'h6000_0000, 32'h7000_0000, 8'd0);
    burst(1'b1, 1, 0, 4'd1, -1, 0);
    n_cmp++; if (o_proto_err !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_err: got %b want 0", o_proto_err); end
  endtask

  task automatic test_bad_rid();
    grant_cycle(2'b01, 1'b0, 32'h9000_0000, 32'h0, 8'd1);
    burst(1'b0, 2, 1, 4'd1, -1, 0);
    n_cmp++; if (o_proto_err !== 1'b1) begin
      n_bad++; $display("FAIL bad_rid_err: got %b want 1", o_proto_err); end
  endtask

  initial begin
    i_reset = 1'b0;
    i_m0_arvalid = 1'b0; i_m1_arvalid = 1'b0;
    i_m0_araddr = 32'd0; i_m1_araddr = 32'd0;
    i_m0_arlen = 8'd0; i_m1_arlen = 8'd0;
    i_m0_arsize = 3'd0; i_m1_arsize = 3'd0;
    i_m0_arburst = 2'd0; i_m1_arburst = 2'd0;
    i_m0_rready = 1'b0; i_m1_rready = 1'b0;
    i_axi_arready = 1'b0; i_axi_rdata = 32'd0; i_axi_rresp = 2'd0;
    i_axi_rid = 4'd0; i_axi_rlast = 1'b0; i_axi_rvalid = 1'b0;

    test_reset();
    test_round_robin();
    test_single_m0();
    test_stall();
    test_early_rlast();
    test_reset_mid_data();
    test_bad_rid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
